// File: rtl/kgp_pkg.sv
// -----------------------------------------------------------------------------
// kgp_pkg
//   Shared constants for the KGP-RISC register file slice.
//   DATA_W   : width of each register and of all data ports
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   REG_ZERO : address of the hardwired-zero register
// -----------------------------------------------------------------------------
package kgp_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W-1:0] regWord_t;
  typedef logic [ADDR_W-1:0] regAddr_t;

endpackage : kgp_pkg

// File: rtl/reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
//   One combinational read port of the register file: selects a register by
//   address, forces the zero register to read 0 and, when the build defines
//   REGFILE_WRITE_BYPASS_EN, forwards the in-flight write data to a reader
//   that addresses the register being written.
// Ports
//   rdData  out DATA_W         selected register value
//   rdAddr  in  ADDR_W         register address to read
//   regs    in  NUM_REGS*DATA_W flattened storage array from reg_file
//   rst     in  1              (bypass build only) reset, suppresses forwarding
//   wrEn    in  1              (bypass build only) write enable
//   wrAddr  in  ADDR_W         (bypass build only) write address
//   wrData  in  DATA_W         (bypass build only) write data
// -----------------------------------------------------------------------------
module reg_read_port
  import kgp_pkg::*;
(
  output logic [DATA_W-1:0]               rdData,
  input  logic [ADDR_W-1:0]               rdAddr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs
`ifdef REGFILE_WRITE_BYPASS_EN
  ,
  input  logic                            rst,
  input  logic                            wrEn,
  input  logic [ADDR_W-1:0]               wrAddr,
  input  logic [DATA_W-1:0]               wrData
`endif
);

  logic [DATA_W-1:0] rdData_s;

`ifdef REGFILE_WRITE_BYPASS_EN
  logic bypassHit_s;

  // Forward only a write that will actually land at the next edge.
  always_comb begin
    bypassHit_s = 1'b0;
    if (wrEn && !rst && (wrAddr == rdAddr) && (wrAddr != REG_ZERO)) begin
      bypassHit_s = 1'b1;
    end else begin
      bypassHit_s = 1'b0;
    end
  end
`endif

  // Address mux with zero-register override (and optional write forwarding).
  always_comb begin
    rdData_s = {DATA_W{1'b0}};
    if (rdAddr == REG_ZERO) begin
      rdData_s = {DATA_W{1'b0}};
`ifdef REGFILE_WRITE_BYPASS_EN
    end else if (bypassHit_s) begin
      rdData_s = wrData;
`endif
    end else begin
      rdData_s = regs[rdAddr];
    end
  end

  assign rdData = rdData_s;

endmodule : reg_read_port

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   32 x 32-bit general-purpose register file for the KGP-RISC datapath.
//   Two combinational read ports (rs -> operand A, rt -> operand B) and one
//   synchronous write port fed by the shifter/ALU result. Register 0 is
//   hardwired to zero. Asynchronous active-high reset clears every register.
//   Build option: define REGFILE_WRITE_BYPASS_EN to make a read of the
//   register being written return wr_data in the same cycle; otherwise the
//   old value is seen until the clock edge.
// Ports
//   clk      in  1       rising-edge clock
//   rst      in  1       asynchronous active-high reset
//   rs_addr  in  ADDR_W  read port 0 address
//   rt_addr  in  ADDR_W  read port 1 address
//   rs_data  out DATA_W  read port 0 data
//   rt_data  out DATA_W  read port 1 data
//   wr_en    in  1       write enable
//   wr_addr  in  ADDR_W  write address
//   wr_data  in  DATA_W  write data
// -----------------------------------------------------------------------------
module reg_file
  import kgp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;

  // Storage: async clear wins over any same-cycle write; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  reg_read_port u_rsPort (
    .rdData (rs_data),
    .rdAddr (rs_addr),
    .regs   (regs_r)
`ifdef REGFILE_WRITE_BYPASS_EN
    ,
    .rst    (rst),
    .wrEn   (wr_en),
    .wrAddr (wr_addr),
    .wrData (wr_data)
`endif
  );

  reg_read_port u_rtPort (
    .rdData (rt_data),
    .rdAddr (rt_addr),
    .regs   (regs_r)
`ifdef REGFILE_WRITE_BYPASS_EN
    ,
    .rst    (rst),
    .wrEn   (wr_en),
    .wrAddr (wr_addr),
    .wrData (wr_data)
`endif
  );

endmodule : reg_file
